// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: I2S master transmitter for the beamformer output stage.
// Accepts left/right PCM pairs over valid/ready into a single holding register
// and serialises them as Philips I2S frames (WS one SCK ahead of each slot,
// MSB first, zero padded to SLOT_BITS). SCK, WS and SD are all registered.
// Optional build macro I2S_TX_UNDERRUN_CNT_EN adds a saturating underrun
// counter (underrun_count) with a synchronous clear input (clr_count).
module i2s_tx_serializer #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned SLOT_BITS = 16,
  parameter int unsigned SCK_HALF  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DATA_BITS-1:0] in_left,
  input  logic [DATA_BITS-1:0] in_right,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 sck,
  output logic                 ws,
  output logic                 sd,
  output logic                 underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  input  logic                 clr_count,
  output logic [7:0]           underrun_count
`endif
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam int unsigned DIV_W      = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int unsigned PAD_BITS   = SLOT_BITS - DATA_BITS;

  localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] WS_HI_FROM = BIT_CNT_W'(SLOT_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] WS_HI_TO   = BIT_CNT_W'(FRAME_BITS - 2);
  localparam logic [DIV_W-1:0]     DIV_LAST   = DIV_W'(SCK_HALF - 1);

  logic [DIV_W-1:0]      div_q, div_d;
  logic                  sck_q, sck_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic                  ws_q, ws_d;
  logic                  sd_q, sd_d;
  logic                  underrun_q, underrun_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0]  hold_l_q, hold_l_d;
  logic [DATA_BITS-1:0]  hold_r_q, hold_r_d;

  logic                  fall_tick_c;
  logic                  frame_start_c;
  logic [FRAME_BITS-1:0] load_c;
  logic [FRAME_BITS-1:0] frame_c;

  // Held pair laid out as two left-justified, zero-padded slots
  assign frame_c = {SLOT_BITS'(hold_l_q) << PAD_BITS, SLOT_BITS'(hold_r_q) << PAD_BITS};

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      sck_q       <= 1'b0;
      bit_q       <= BIT_LAST;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
      underrun_q  <= 1'b0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
    end else begin
      div_q       <= div_d;
      sck_q       <= sck_d;
      bit_q       <= bit_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
      underrun_q  <= underrun_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
    end
  end

  // Divider, bit counter, frame loading and handshake next-state
  always_comb begin
    div_d         = div_q;
    sck_d         = sck_q;
    bit_d         = bit_q;
    ws_d          = ws_q;
    sd_d          = sd_q;
    underrun_d    = 1'b0;
    shift_d       = shift_q;
    hold_full_d   = hold_full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    fall_tick_c   = 1'b0;
    frame_start_c = 1'b0;
    load_c        = shift_q;

    if (!en) begin
      // Disabled: serial side parked at reset values, any frame in flight dropped
      div_d   = '0;
      sck_d   = 1'b0;
      bit_d   = BIT_LAST;
      ws_d    = 1'b0;
      sd_d    = 1'b0;
      shift_d = '0;
    end else begin
      if (div_q == DIV_LAST) begin
        div_d       = '0;
        sck_d       = ~sck_q;
        fall_tick_c = sck_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end

      if (fall_tick_c) begin
        frame_start_c = (bit_q == BIT_LAST);
        bit_d         = frame_start_c ? '0 : bit_q + BIT_CNT_W'(1);
        ws_d          = (bit_d >= WS_HI_FROM) && (bit_d <= WS_HI_TO);
        if (frame_start_c) begin
          load_c      = hold_full_q ? frame_c : '0;
          underrun_d  = ~hold_full_q;
          hold_full_d = 1'b0;
        end
        sd_d    = load_c[FRAME_BITS-1];
        shift_d = load_c << 1;
      end
    end

    // Handshake stays live regardless of en; a full hold blocks new transfers
    if (in_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_l_d    = in_left;
      hold_r_d    = in_right;
    end
  end

  assign in_ready = ~hold_full_q;
  assign sck      = sck_q;
  assign ws       = ws_q;
  assign sd       = sd_q;
  assign underrun = underrun_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q, ucnt_d;

  // Saturating underrun counter; clear has priority over increment
  always_comb begin
    ucnt_d = ucnt_q;
    if (clr_count) begin
      ucnt_d = '0;
    end else if (underrun_q && (ucnt_q != 8'hFF)) begin
      ucnt_d = ucnt_q + 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed self-checking bench for i2s_tx_serializer (DATA_BITS=8, SLOT_BITS=16,
// SCK_HALF=2: SCK period 4 clk, frame 128 clk, first frame start on the 4th
// posedge after en/reset release). Inputs change and outputs are sampled on
// the falling clk edge.
module tb_i2s_tx_serializer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] in_left;
  logic [7:0] in_right;
  logic       in_valid;
  logic       in_ready;
  logic       sck;
  logic       ws;
  logic       sd;
  logic       underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic       clr_count;
  logic [7:0] underrun_count;
`endif

  int n_chk;
  int n_bad;

  i2s_tx_serializer #(
    .DATA_BITS(8),
    .SLOT_BITS(16),
    .SCK_HALF (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .in_left (in_left),
    .in_right(in_right),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sck     (sck),
    .ws      (ws),
    .sd      (sd),
    .underrun(underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .clr_count     (clr_count),
    .underrun_count(underrun_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Entered just after a frame-start edge; captures one 32-bit frame of sd/ws
  // (one sample per SCK, at the fall tick), counts underrun pulses and checks
  // the SCK waveform. Leaves off just after the next frame-start edge.
  task automatic run_frame(input string tag, input logic [31:0] exp_sd, input int exp_ur);
    logic [31:0] sdb;
    logic [31:0] wsb;
    int          urs;
    int          sck_bad;
    sdb = '0; wsb = '0; urs = 0; sck_bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (i % 4 == 0) begin
        sdb[31 - i/4] = sd;
        wsb[31 - i/4] = ws;
      end
      if (underrun === 1'b1) urs++;
      if (sck !== ((i % 4) >= 2)) sck_bad++;
      @(negedge clk);
    end
    chk({tag, "_sd"}, sdb, exp_sd);
    chk({tag, "_ws"}, wsb, 32'h0001_FFFE);
    chk({tag, "_underruns"}, 32'(urs), 32'(exp_ur));
    chk({tag, "_sck_errs"}, 32'(sck_bad), 32'd0);
  endtask

  // Feeds three pairs back to back with in_valid held high
  task automatic feed_three();
    int guard;
    for (int k = 0; k < 3; k++) begin
      in_left  = 8'(2*k + 1);
      in_right = 8'(2*k + 2);
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      chk("t3_ready_wait", 32'(guard < 300), 32'd1);
      @(negedge clk);
      chk("t3_ready_low_after_accept", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    clr_count = 1'b0;
`endif
    step(2);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_ws", 32'(ws), 32'd0);
    chk("rst_sd", 32'(sd), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: idle with en=1, underrun every frame
    rst_n = 1'b1; en = 1'b1;
    step(1); chk("t1_sck_e1", 32'(sck), 32'd0);
    step(1); chk("t1_sck_e2", 32'(sck), 32'd1);
    step(1); chk("t1_sck_e3", 32'(sck), 32'd1);
    step(1); chk("t1_ur_first_start", 32'(underrun), 32'd1);
    run_frame("t1_f1", 32'h0, 1);
    run_frame("t1_f2", 32'h0, 1);

    // 2: pair pushed before first frame start
    rst_n = 1'b0; en = 1'b0;
    step(1);
    rst_n = 1'b1;
    in_left = 8'hA5; in_right = 8'h3C; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    chk("t2_ready_low", 32'(in_ready), 32'd0);
    en = 1'b1;
    step(4);
    run_frame("t2", 32'hA500_3C00, 0);

    // 3: back-to-back pairs with in_valid held high
    rst_n = 1'b0; en = 1'b0;
    step(1);
    rst_n = 1'b1; en = 1'b1;
    fork
      feed_three();
      begin
        step(4);
        run_frame("t3_f1", 32'h0100_0200, 0);
        run_frame("t3_f2", 32'h0300_0400, 0);
        run_frame("t3_f3", 32'h0500_0600, 0);
      end
    join

    // 4: transfer in the same clk as a frame start with hold empty
    step(127);
    in_left = 8'h77; in_right = 8'h88; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    chk("t4_ready_low", 32'(in_ready), 32'd0);
    chk("t4_underrun", 32'(underrun), 32'd1);
    run_frame("t4_zero", 32'h0, 1);
    run_frame("t4_pair", 32'h7700_8800, 0);

    // 5: drop en mid-left-slot with a pair pending, then restart
    in_left = 8'hFF; in_right = 8'h11; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(127);
    in_left = 8'h96; in_right = 8'h69; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(5);
    chk("t5_sck_before", 32'(sck), 32'd1);
    chk("t5_sd_before", 32'(sd), 32'd1);
    en = 1'b0;
    step(1);
    chk("t5_sck_off", 32'(sck), 32'd0);
    chk("t5_ws_off", 32'(ws), 32'd0);
    chk("t5_sd_off", 32'(sd), 32'd0);
    step(10);
    chk("t5_sck_idle", 32'(sck), 32'd0);
    chk("t5_hold_kept", 32'(in_ready), 32'd0);
    en = 1'b1;
    step(1); chk("t5_sck_e1", 32'(sck), 32'd0);
    step(1); chk("t5_sck_e2", 32'(sck), 32'd1);
    step(2); chk("t5_no_underrun", 32'(underrun), 32'd0);
    run_frame("t5_restart", 32'h9600_6900, 0);

    // 6: async reset mid-frame with hold full
    in_left = 8'hC3; in_right = 8'h5A; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    chk("t6_ready_low", 32'(in_ready), 32'd0);
    step(41);
    rst_n = 1'b0;
    #1;
    chk("t6_sck", 32'(sck), 32'd0);
    chk("t6_ws", 32'(ws), 32'd0);
    chk("t6_sd", 32'(sd), 32'd0);
    chk("t6_underrun", 32'(underrun), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(4);
    chk("t6_lost_underrun", 32'(underrun), 32'd1);
    run_frame("t6_lost", 32'h0, 1);

`ifdef I2S_TX_UNDERRUN_CNT_EN
    // Counter saturation and clear
    rst_n = 1'b0;
    step(1);
    chk("cnt_rst", 32'(underrun_count), 32'd0);
    rst_n = 1'b1;
    step(4 + 128*300 + 10);
    chk("cnt_sat", 32'(underrun_count), 32'd255);
    clr_count = 1'b1;
    step(1);
    clr_count = 1'b0;
    chk("cnt_clr", 32'(underrun_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
